// File: rtl/ping_pkg.sv
// ping_pkg: shared state encoding, dead-time build switch and sizing helpers for ping_burst_tx.
// Build macro PING_DEAD_TIME_EN enables per-half-period dead time on the drive pair.
package ping_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_BURST  = 3'd1;
  localparam state_t S_BLANK  = 3'd2;
  localparam state_t S_LISTEN = 3'd3;
  localparam state_t S_DONE   = 3'd4;
`ifdef PING_DEAD_TIME_EN
  localparam bit DEAD_TIME_EN = 1'b1;
`else
  localparam bit DEAD_TIME_EN = 1'b0;
`endif
  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic bit params_ok(input int half_period, pulses, blank_cycles, listen_cycles, dead_cycles);
    return half_period >= 1 && pulses >= 1 && blank_cycles >= 0 && listen_cycles >= 1 &&
           dead_cycles >= 0 && dead_cycles < half_period;
  endfunction
endpackage

// File: rtl/ping_tick_gen.sv
// ping_tick_gen: half-period divider with one-cycle tick and next-cycle dead-time flag.
// Ports: clk, rst_n (async active-low); clr restarts the half-period; en advances it;
// tick marks the last clock of a half-period; dead_nxt says the coming cycle is dead time
// (only when PING_DEAD_TIME_EN is defined).
module ping_tick_gen
  import ping_pkg::*;
#(
  parameter int HALF_PERIOD = 625,
  parameter int DEAD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick,
  output logic dead_nxt
);
  localparam int CW = cw(HALF_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] DEAD = CW'(DEAD_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = en && cnt_q == LAST;
    cnt_d = (clr || tick) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    dead_nxt = DEAD_TIME_EN && cnt_d < DEAD;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/ping_burst_tx.sv
// ping_burst_tx: ultrasonic ping transmitter - burst, ring-down blanking, bounded listen window.
// Ports: SYS_CLK, SYS_RST_N (async active-low); ON enable/abort; trigger start request;
// echo_det echo input; tx_p/tx_n complementary drives; timer_rst/timer_stop to the detection
// timer; listen_en, busy, done (one-cycle), hit (echo vs timeout, held). All outputs registered.
// Build macro PING_DEAD_TIME_EN inserts DEAD_CYCLES of both-low at the start of each half-period.
module ping_burst_tx
  import ping_pkg::*;
#(
  parameter int HALF_PERIOD   = 625,
  parameter int PULSES        = 8,
  parameter int BLANK_CYCLES  = 2000,
  parameter int LISTEN_CYCLES = 1000,
  parameter int DEAD_CYCLES   = 4
) (
  input  logic SYS_CLK,
  input  logic SYS_RST_N,
  input  logic ON,
  input  logic trigger,
  input  logic echo_det,
  output logic tx_p,
  output logic tx_n,
  output logic timer_rst,
  output logic timer_stop,
  output logic listen_en,
  output logic busy,
  output logic done,
  output logic hit
);
  localparam int PULSE_W = cw(2 * PULSES);
  localparam int PHASE_W = cw(BLANK_CYCLES > LISTEN_CYCLES ? BLANK_CYCLES : LISTEN_CYCLES);
  // An illegal configuration never leaves IDLE.
  localparam bit PARAM_OK = params_ok(HALF_PERIOD, PULSES, BLANK_CYCLES, LISTEN_CYCLES, DEAD_CYCLES);
  localparam logic [PULSE_W-1:0] LAST_HALF   = PULSE_W'(2 * PULSES - 1);
  localparam logic [PHASE_W-1:0] LAST_BLANK  = PHASE_W'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
  localparam logic [PHASE_W-1:0] LAST_LISTEN = PHASE_W'(LISTEN_CYCLES - 1);
  state_t state_q, state_d;
  logic [PULSE_W-1:0] half_q, half_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic hit_q, hit_d, tx_p_q, tx_p_d, tx_n_q, tx_n_d, timer_rst_q, timer_rst_d;
  logic timer_stop_q, timer_stop_d, listen_en_q, listen_en_d, busy_q, busy_d, done_q, done_d;
  logic start, tick, dead_nxt;
  assign start = state_q == S_IDLE && trigger && ON && PARAM_OK;
  ping_tick_gen #(.HALF_PERIOD(HALF_PERIOD), .DEAD_CYCLES(DEAD_CYCLES)) u_tick (
    .clk(SYS_CLK), .rst_n(SYS_RST_N), .clr(start || !ON), .en(state_q == S_BURST),
    .tick(tick), .dead_nxt(dead_nxt)
  );
  always_comb begin
    state_d = state_q;
    half_d = half_q;
    phase_d = phase_q;
    hit_d = hit_q;
    if (!ON) state_d = S_IDLE;
    else case (state_q)
      S_IDLE: if (start) begin
        state_d = S_BURST;
        half_d = '0;
      end
      S_BURST: if (tick) begin
        half_d = (half_q == LAST_HALF) ? '0 : half_q + 1'b1;
        phase_d = '0;
        if (half_q == LAST_HALF) state_d = (BLANK_CYCLES == 0) ? S_LISTEN : S_BLANK;
      end
      S_BLANK: begin
        phase_d = (phase_q == LAST_BLANK) ? '0 : phase_q + 1'b1;
        if (phase_q == LAST_BLANK) state_d = S_LISTEN;
      end
      S_LISTEN: begin
        phase_d = phase_q + 1'b1;
        // An echo on the final window cycle still wins over the timeout.
        if (echo_det || phase_q == LAST_LISTEN) begin
          state_d = S_DONE;
          phase_d = '0;
          hit_d = echo_det;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered, so they are decoded from the next state.
    tx_p_d = state_d == S_BURST && !half_d[0] && !dead_nxt;
    tx_n_d = state_d == S_BURST && half_d[0] && !dead_nxt;
    timer_rst_d = start;
    timer_stop_d = state_d == S_IDLE || state_d == S_DONE;
    listen_en_d = state_d == S_LISTEN;
    busy_d = state_d != S_IDLE;
    done_d = state_d == S_DONE;
  end
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N)
    if (!SYS_RST_N) begin
      state_q <= S_IDLE;
      half_q <= '0;
      phase_q <= '0;
      hit_q <= 1'b0;
      tx_p_q <= 1'b0;
      tx_n_q <= 1'b0;
      timer_rst_q <= 1'b0;
      timer_stop_q <= 1'b1;
      listen_en_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q <= half_d;
      phase_q <= phase_d;
      hit_q <= hit_d;
      tx_p_q <= tx_p_d;
      tx_n_q <= tx_n_d;
      timer_rst_q <= timer_rst_d;
      timer_stop_q <= timer_stop_d;
      listen_en_q <= listen_en_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  assign tx_p = tx_p_q;
  assign tx_n = tx_n_q;
  assign timer_rst = timer_rst_q;
  assign timer_stop = timer_stop_q;
  assign listen_en = listen_en_q;
  assign busy = busy_q;
  assign done = done_q;
  assign hit = hit_q;
endmodule

// File: doc/ping_burst_tx.md
Name: ping_burst_tx

Overview:
Transmit-side companion to the echo detection timer. On a trigger it drives a complementary ultrasonic burst onto the transducer pair and emits the one-cycle timer reset that starts time-of-flight counting. It then blanks out transducer ring-down and opens a bounded listen window that closes on echo or timeout. Sits between the system sequencer (trigger/ON) and the transducer driver pins; its timer_rst/timer_stop outputs feed the detection timer directly.

Parameters:
HALF_PERIOD, 625, clocks per drive half-period (625 gives 40 kHz at 50 MHz); must be >=1
PULSES, 8, full drive cycles per burst; must be >=1
BLANK_CYCLES, 2000, ring-down clocks with both drives low and no listening; 0 skips BLANK
LISTEN_CYCLES, 1000, listen-window length in clocks; must be >=1
DEAD_CYCLES, 4, dead-time clocks at the start of each half-period (used only with DEAD_TIME_EN); must be < HALF_PERIOD

Ports:
SYS_CLK  in  1  system clock, all logic on rising edge
SYS_RST_N  in  1  asynchronous active-low reset
ON  in  1  block enable; low aborts and holds IDLE
trigger  in  1  start request, level-sampled in IDLE
echo_det  in  1  echo detected (already synchronous to SYS_CLK)
tx_p  out  1  transducer drive, positive phase
tx_n  out  1  transducer drive, negative phase
timer_rst  out  1  one-cycle pulse at burst start, to detection timer
timer_stop  out  1  high from end of listen window until next burst start
listen_en  out  1  high during LISTEN
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on listen-window close
hit  out  1  valid with done: 1 = echo, 0 = timeout; holds until next done

Behaviour:
- Reset (async assert, sync release): state IDLE; tx_p=tx_n=timer_rst=listen_en=busy=done=hit=0; timer_stop=1. All outputs registered.
- States: IDLE, BURST, BLANK, LISTEN, DONE.
- IDLE: trigger=1 and ON=1 at edge k -> BURST from edge k. timer_rst=1 for exactly that cycle; timer_stop drops to 0 at edge k.
- BURST: tx_p=1 for HALF_PERIOD cycles, then tx_n=1 for HALF_PERIOD cycles, repeated PULSES times; total 2*PULSES*HALF_PERIOD cycles. tx_p and tx_n are never both 1.
- BLANK: both drives 0 for BLANK_CYCLES; BLANK_CYCLES=0 goes BURST -> LISTEN directly.
- LISTEN: listen_en=1. echo_det is ignored outside LISTEN. echo_det sampled 1 -> DONE with hit=1. LISTEN_CYCLES elapse with no echo -> DONE with hit=0. Echo on the final listen cycle counts as a hit.
- DONE: lasts one cycle. done=1, timer_stop=1, then IDLE. timer_stop stays 1 until the next burst.
- trigger is ignored outside IDLE; no queuing. Held trigger re-fires on the first IDLE cycle after DONE.
- ON=0 in any state: at next edge go to IDLE with drives 0, listen_en=0, timer_stop=1, and no done pulse. hit is unchanged.
- Counters: half-period counter ceil(log2(HALF_PERIOD)) bits; pulse counter ceil(log2(2*PULSES)) bits; one shared phase counter sized for max(BLANK_CYCLES, LISTEN_CYCLES), reset on each state entry. No wrap-around reachable.

Optional Feature:
PING_DEAD_TIME_EN
- Defined: the first DEAD_CYCLES cycles of every half-period drive both tx_p and tx_n low (H-bridge shoot-through protection). Burst length is unchanged.
- Undefined: no dead time; DEAD_CYCLES is unused.

Decomposition:
- Package ping_pkg: state enum type; parameter-check constants; counter-width helper function.
- Sub-module ping_tick_gen: half-period divider emitting a one-cycle tick every HALF_PERIOD clocks, plus dead-time flag; cleared on burst start and on ON=0.

Test Plan:
- Basic burst, HALF_PERIOD=4, PULSES=2, BLANK=3, LISTEN=20, trigger at edge 10 -> timer_rst high cycle 10 only; tx_p 10-13, tx_n 14-17, tx_p 18-21, tx_n 22-25; BLANK 26-28; listen_en 29-48; done at 49 with hit=0.
- Echo hit: same config, echo_det=1 at cycle 35 -> DONE at 36 with done=1, hit=1, timer_stop=1 from 36.
- Echo outside LISTEN: echo_det=1 during BURST and BLANK -> ignored; timeout result is unchanged (hit=0).
- Abort: ON=0 at cycle 20 mid-burst -> IDLE at 21, drives 0, no done pulse, hit unchanged; a new trigger afterwards restarts cleanly.
- Async reset asserted mid-LISTEN -> all outputs at reset values immediately, timer_stop=1; normal burst after release.
- With PING_DEAD_TIME_EN, DEAD_CYCLES=1 -> first cycle of each half-period has both drives 0; tx_p&tx_n never 1 (assertion over all runs).
